// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 encodings, FSM state type and request legality check.
//   bad_req(we, funct3, off) returns 1 for a misaligned access or an illegal funct3.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {IDLE, STORE, LOAD, CAPT, ERR} state_t;

    function automatic logic bad_req(input logic we, input logic [2:0] f3, input logic [1:0] off);
        return we ? (f3 == F3_SH ? off[0] : f3 == F3_SW ? |off : f3 != F3_SB)
                  : (f3 == F3_LH || f3 == F3_LHU) ? off[0]
                  : f3 == F3_LW ? |off
                  : !(f3 == F3_LB || f3 == F3_LBU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for stores and loads.
//   off    in  2   byte offset within the word
//   funct3 in  3   access size/sign
//   wdata  in  32  right-aligned store data
//   rdata  in  32  raw memory word
//   be     out 4   byte write enables
//   wrep   out 32  store data replicated into lanes
//   rext   out 32  selected and extended load data
module lsu_align (
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic [31:0] rext
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    assign b  = rdata[{off, 3'b000} +: 8];
    assign h  = off[1] ? rdata[31:16] : rdata[15:0];
    // funct3[2] marks the unsigned load variants
    assign sx = ~funct3[2];

    assign be   = funct3[1:0] == 2'b00 ? 4'b0001 << off
                : funct3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011)
                : 4'b1111;
    assign wrep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}}
                : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}}
                : wdata;
    assign rext = funct3[1:0] == 2'b00 ? {{24{sx & b[7]}}, b}
                : funct3[1:0] == 2'b01 ? {{16{sx & h[15]}}, h}
                : rdata;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store FSM between execute stage and data memory.
//   clk, rst                          clock, async active-high reset
//   req_valid/ready/we/funct3/addr/wdata  request handshake and payload
//   resp_valid/err/rdata              one-cycle response pulse
//   mem_rd/we/addr/wdata, mem_rdata   word-aligned data memory port (1-cycle read latency)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_rd,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t      state, state_n;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] wd_q;
    logic [3:0]  be;
    logic [31:0] rext;

    lsu_align u_align (
        .off    (off_q),
        .funct3 (f3_q),
        .wdata  (wd_q),
        .rdata  (mem_rdata),
        .be     (be),
        .wrep   (mem_wdata),
        .rext   (rext)
    );

    assign req_ready = state == IDLE;
    assign mem_rd    = state == LOAD;
    assign mem_we    = state == STORE ? be : 4'b0000;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = bad_req(req_we, req_funct3, req_addr[1:0]) ? ERR : req_we ? STORE : LOAD;
            LOAD:    state_n = CAPT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off_q      <= '0;
            f3_q       <= '0;
            wd_q       <= '0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_n;
            if (req_ready && req_valid) begin
                off_q    <= req_addr[1:0];
                f3_q     <= req_funct3;
                wd_q     <= req_wdata;
                mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            end
            resp_valid <= state inside {STORE, CAPT, ERR};
            resp_err   <= state == ERR;
            resp_rdata <= state == CAPT ? rext : 32'h0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, reset corner cases and randomized
// transactions checked against a byte-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_rd;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    logic [7:0]  rb [64];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[5:2]];
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) mem[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwd;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return a[0] == 1'b0;
            3'd2:    return a[1:0] == 2'b00;
            3'd4:    return !we;
            3'd5:    return !we && a[0] == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int i;
        logic [31:0] v;
        i = int'(a[5:0]);
        v = 32'h0;
        for (int k = 0; k < size_of(f3); k++) v[8*k +: 8] = rb[i+k];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic init_mem();
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int k = 0; k < 4; k++) rb[4*i+k] = w[8*k +: 8];
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output int nrd, output int nwe, output logic [3:0] be_s,
                        output logic [31:0] wd_s, output logic [31:0] ad_s);
        lat = 0; err = 1'b0; rd = 32'h0; nrd = 0; nwe = 0; be_s = 4'h0; wd_s = 32'h0; ad_s = 32'h0;
        chk("req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            if (mem_rd) begin nrd++; ad_s = mem_addr; end
            if (mem_we != 4'h0) begin nwe++; be_s = mem_we; wd_s = mem_wdata; ad_s = mem_addr; end
            if (resp_valid) begin lat = c; err = resp_err; rd = resp_rdata; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_and_verify(input string tag, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                                  input logic [3:0] exp_be, input logic [31:0] exp_mwd);
        int lat, nrd, nwe;
        logic err;
        logic [31:0] rd, wd_s, ad_s;
        logic [3:0] be_s;
        xact(we, f3, a, wd, lat, err, rd, nrd, nwe, be_s, wd_s, ad_s);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " resp_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, " resp_rdata"}, rd, exp_rd);
        chk({tag, " mem_rd count"}, nrd, (!exp_err && !we) ? 1 : 0);
        chk({tag, " mem_we count"}, nwe, (!exp_err && we) ? 1 : 0);
        chk({tag, " mem_we"}, {28'b0, be_s}, {28'b0, exp_be});
        if (!exp_err) chk({tag, " mem_addr"}, ad_s, a & 32'hFFFFFFFC);
        if (!exp_err && we) chk({tag, " mem_wdata"}, wd_s & lane_mask(exp_be), exp_mwd & lane_mask(exp_be));
    endtask

    initial begin
        int lat, nrd, nwe, pulses;
        logic err;
        logic [31:0] rd, wd_s, ad_s, a, wd, exp_mwd;
        logic [3:0] be_s, exp_be;
        logic we, ok;
        logic [2:0] f3;

        vt[0]  = '{1'b1, 3'b000, 32'h00000006, 32'h000000A5, 32'h0,        1'b0, 2, 4'b0100, 32'hA5A5A5A5};
        vt[1]  = '{1'b0, 3'b000, 32'h00000003, 32'h0,        32'hFFFFFF80, 1'b0, 3, 4'b0000, 32'h0};
        vt[2]  = '{1'b0, 3'b100, 32'h00000003, 32'h0,        32'h00000080, 1'b0, 3, 4'b0000, 32'h0};
        vt[3]  = '{1'b0, 3'b101, 32'h00000002, 32'h0,        32'h000080FF, 1'b0, 3, 4'b0000, 32'h0};
        vt[4]  = '{1'b0, 3'b001, 32'h00000002, 32'h0,        32'hFFFF80FF, 1'b0, 3, 4'b0000, 32'h0};
        vt[5]  = '{1'b0, 3'b010, 32'h00100004, 32'h0,        32'h11A53344, 1'b0, 3, 4'b0000, 32'h0};
        vt[6]  = '{1'b1, 3'b001, 32'h00000001, 32'h00001234, 32'h0,        1'b1, 2, 4'b0000, 32'h0};
        vt[7]  = '{1'b0, 3'b010, 32'h00000002, 32'h0,        32'h0,        1'b1, 2, 4'b0000, 32'h0};
        vt[8]  = '{1'b1, 3'b010, 32'h00000008, 32'hDEADBEEF, 32'h0,        1'b0, 2, 4'b1111, 32'hDEADBEEF};
        vt[9]  = '{1'b0, 3'b010, 32'h00000008, 32'h0,        32'hDEADBEEF, 1'b0, 3, 4'b0000, 32'h0};
        vt[10] = '{1'b1, 3'b001, 32'h0000000E, 32'h0000BEEF, 32'h0,        1'b0, 2, 4'b1100, 32'hBEEFBEEF};
        vt[11] = '{1'b0, 3'b010, 32'h0000000C, 32'h0,        32'hBEEF0000, 1'b0, 3, 4'b0000, 32'h0};
        vt[12] = '{1'b0, 3'b011, 32'h00000000, 32'h0,        32'h0,        1'b1, 2, 4'b0000, 32'h0};
        vt[13] = '{1'b1, 3'b100, 32'h00000000, 32'h000000FF, 32'h0,        1'b1, 2, 4'b0000, 32'h0};
        vt[14] = '{1'b0, 3'b000, 32'h00000001, 32'h0,        32'h00000012, 1'b0, 3, 4'b0000, 32'h0};

        init_mem();
        mem[0] = 32'h80FF1234;
        mem[1] = 32'h11223344;
        mem[3] = 32'h00000000;

        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h12345678; req_wdata = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset resp_err", {31'b0, resp_err}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("reset mem_we", {28'b0, mem_we}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-reset req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 15; i++)
            run_and_verify($sformatf("vec%0d", i), vt[i].we, vt[i].f3, vt[i].a, vt[i].wd,
                           vt[i].exp_err, vt[i].exp_rd, vt[i].exp_lat, vt[i].exp_be, vt[i].exp_mwd);

        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00000010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("midrst mem_rd in LOAD", {31'b0, mem_rd}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("midrst mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("midrst no response", pulses, 0);
        run_and_verify("post-rst SW", 1'b1, 3'b010, 32'h00000014, 32'h0BADF00D,
                       1'b0, 32'h0, 2, 4'b1111, 32'h0BADF00D);
        chk("post-rst SW memory", mem[5], 32'h0BADF00D);

        init_mem();
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom_range(0, 1023), 6'($urandom)} ^ {26'($urandom), 6'b0};
            wd = $urandom;
            ok = legal(we, f3, a);
            exp_be = 4'h0;
            exp_mwd = 32'h0;
            if (ok && we)
                for (int k = 0; k < size_of(f3); k++) begin
                    exp_be[a[1:0] + 2'(k)] = 1'b1;
                    exp_mwd[8*(int'(a[1:0]) + k) +: 8] = wd[8*k +: 8];
                end
            run_and_verify($sformatf("rnd%0d", n), we, f3, a, wd, !ok,
                           (ok && !we) ? model_load(f3, a) : 32'h0, (ok && !we) ? 3 : 2, exp_be, exp_mwd);
            if (ok && we)
                for (int k = 0; k < size_of(f3); k++) rb[int'(a[5:0]) + k] = wd[8*k +: 8];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
